issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

Register-hazard scoreboard and issue register sitting directly after the decode latch, consuming its registered outputs. It holds the decoded instruction when any source or destination register is still owned by an in-flight instruction, or when the in-flight window is full. Otherwise it issues the instruction into a one-entry issue register toward execute and marks its destination busy. Writeback releases busy registers.

## Interface

**Parameters**

- `NUM_REGS`, 32: architectural registers; x0 is never tracked.
- `MAX_INFLIGHT`, 4: maximum issued-but-not-written-back instructions with a destination.
- `PERF_W`, 16: width of the stall-cycle counter.

**Ports**

- `stg_clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low (asserted at 0); clears all state immediately.
- `in_valid` input 1: decode latch holds a valid instruction.
- `in_pc` input 32: instruction PC.
- `in_rs1`, `in_rs2`, `in_rd` input 5 each: register indices.
- `in_rs1_used`, `in_rs2_used` input 1 each: source actually read.
- `in_save_to_reg` input 1: instruction writes `in_rd`.
- `in_rd_memory` input 1: load.
- `flush` input 1: branch mispredict; kill the instruction currently presented.
- `wb_valid` input 1: writeback this cycle.
- `wb_rd` input 5: register being written back.
- `stall` output 1: combinational; decode latch must hold (deassert its `stg_ena`).
- `stall_cause` output 2: combinational; 0 none, 1 RAW, 2 WAW, 3 window full.
- `issue_valid` output 1: registered; issue register holds a live instruction.
- `issue_pc` output 32, `issue_rd` output 5, `issue_save_to_reg` output 1, `issue_rd_memory` output 1: registered copies of the issued fields.
- `busy_mask` output NUM_REGS: registered busy bits; bit 0 is always 0.
- `inflight_count` output clog2(MAX_INFLIGHT+1): registered.
- `stall_cycles` output PERF_W: saturating count of cycles with `stall`=1.

## Operation

- Effective busy: `eff_busy = busy_mask & ~(wb_valid ? onehot(wb_rd) : 0)`. Writeback in the same cycle resolves the hazard because the register file is write-through.
- RAW: (`in_rs1_used` & `eff_busy[in_rs1]`) | (`in_rs2_used` & `eff_busy[in_rs2]`).
- WAW: `in_save_to_reg` & `in_rd`≠0 & `eff_busy[in_rd]`.
- Destination-carrying instruction ("dst"): `in_save_to_reg` & `in_rd`≠0.
- Window full: dst & (`inflight_count` − (`wb_valid` & `busy_mask[wb_rd]`)) == MAX_INFLIGHT.
- `stall` = `in_valid` & ~`flush` & (RAW | WAW | full). When several causes apply, `stall_cause` priority is RAW > WAW > full.
- Issue condition: `in_valid` & ~`flush` & ~`stall`.
- On issue:
  - Load the issue register.
  - If dst, set `busy_mask[in_rd]`.
  - If dst, increment `inflight_count`.
- Otherwise `issue_valid` becomes 0 (bubble). The other issue fields hold their old values.
- On `wb_valid` with `busy_mask[wb_rd]`=1: clear that bit and decrement `inflight_count`.
- Writeback to a non-busy register, or to x0, is ignored: no bit change, no decrement.
- Same-cycle issue and writeback: the clear and the set apply together, and the count change is net (+1, −1, or 0). Same-rd conflicts cannot occur because WAW stalls.
- Two-state FSM:
  - RUN → HOLD when `stall`.
  - HOLD → RUN when not `stall`.
  - HOLD has priority 0 vs flush: `flush` forces RUN.
- `stall_cycles` increments in any cycle with `stall`=1 and saturates at all-ones.
- `flush` does not clear busy bits. Already-issued instructions still write back.

## Timing

- Issue latency: one cycle. An instruction presented at edge N with no stall has `issue_valid`=1 after edge N+1.
- `stall` and `stall_cause` are combinational from the inputs and registered state, with no latch-through.
- A busy bit set at an edge blocks dependents evaluated in the following cycle (no forwarding from issue).
- Reset asserted, at any time including mid-stall, forces immediately:
  - `issue_valid`=0 and all issue fields 0.
  - `busy_mask`=0, `inflight_count`=0, `stall_cycles`=0.
  - FSM=RUN.
- While reset is asserted, `stall`=0 regardless of inputs.

## Structure

- Shared package `pipeline_pkg` holds:
  - the `stall_cause` encodings (`STALL_NONE`, `STALL_RAW`, `STALL_WAW`, `STALL_FULL`);
  - the FSM state constants (`SB_RUN`, `SB_HOLD`);
  - the register index width of 5.
- One natural sub-module: `reg_busy_table`. It holds the busy bits, with set/clear ports and a combined-clear output `eff_busy`.
- Counter, FSM, and issue register live in the top module.

## Test plan

- Independent stream: `rd` = 1, 2, 3 with no source overlap and no writeback → no stall. `issue_valid`=1 on consecutive cycles. `busy_mask`=0x0000000E. `inflight_count`=3.
- RAW on a load: issue ld x5 → next instruction add with rs1=x5 → `stall`=1, `stall_cause`=1 until `wb_valid`,`wb_rd`=5. Add issues at the edge after that writeback cycle. `stall_cycles` equals the held cycle count.
- Window full: with MAX_INFLIGHT=4, issue 4 dst instructions, then present a 5th → `stall_cause`=3. Assert `wb_valid` for x1 in the same cycle → 5th issues and `inflight_count` stays 4.
- WAW and x0: pending x7, present write to x7 → `stall_cause`=2. Present write to x0 while x0 is "written back" → no stall, `busy_mask[0]`=0, count unchanged.
- Flush during hold: RAW stall active, assert `flush` → `stall`=0, `issue_valid`=0 next cycle, busy bits unchanged, FSM=RUN.
- Reset mid-operation: after 3 in-flight instructions and an active stall, pull `reset` low between edges → all outputs 0 immediately. After release, the first independent instruction issues with one-cycle latency.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared pipeline definitions: register index width, stall-cause encodings
// and scoreboard FSM states.
package pipeline_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        STALL_NONE = 2'd0,
        STALL_RAW  = 2'd1,
        STALL_WAW  = 2'd2,
        STALL_FULL = 2'd3
    } stall_cause_e;

    typedef enum logic {
        SB_RUN  = 1'b0,
        SB_HOLD = 1'b1
    } sb_state_e;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue handshake: decoded instruction, flush, writeback, and the
// stall/issue results returned by the scoreboard.
interface issue_scoreboard_if
    import pipeline_pkg::*;
;
    logic                 in_valid;
    logic [31:0]          in_pc;
    logic [REG_IDX_W-1:0] in_rs1;
    logic [REG_IDX_W-1:0] in_rs2;
    logic [REG_IDX_W-1:0] in_rd;
    logic                 in_rs1_used;
    logic                 in_rs2_used;
    logic                 in_save_to_reg;
    logic                 in_rd_memory;
    logic                 flush;
    logic                 wb_valid;
    logic [REG_IDX_W-1:0] wb_rd;

    logic                 stall;
    stall_cause_e         stall_cause;
    logic                 issue_valid;
    logic [31:0]          issue_pc;
    logic [REG_IDX_W-1:0] issue_rd;
    logic                 issue_save_to_reg;
    logic                 issue_rd_memory;

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_rs1_used, in_rs2_used,
               in_save_to_reg, in_rd_memory, flush, wb_valid, wb_rd,
        input  stall, stall_cause, issue_valid, issue_pc, issue_rd,
               issue_save_to_reg, issue_rd_memory
    );

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_rs1_used, in_rs2_used,
               in_save_to_reg, in_rd_memory, flush, wb_valid, wb_rd,
        output stall, stall_cause, issue_valid, issue_pc, issue_rd,
               issue_save_to_reg, issue_rd_memory
    );

endinterface

// File: rtl/issue_scoreboard_reg_busy_table.sv
// Per-register busy bits with one set port (issue) and one clear port
// (writeback); eff_busy_o already reflects this cycle's clear.
module reg_busy_table
    import pipeline_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 set_i,
    input  logic [REG_IDX_W-1:0] set_idx_i,
    input  logic                 clr_i,
    input  logic [REG_IDX_W-1:0] clr_idx_i,
    output logic [NUM_REGS-1:0]  busy_o,
    output logic [NUM_REGS-1:0]  eff_busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_mask, clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_i) set_mask[set_idx_i] = 1'b1;
        if (clr_i) clr_mask[clr_idx_i] = 1'b1;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        // x0 is hard-wired, so it is never tracked
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign busy_o     = busy_q;
    assign eff_busy_o = busy_q & ~clr_mask;

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard plus one-entry issue register: stalls decode on
// RAW/WAW hazards or a full in-flight window, otherwise issues and marks rd busy.
module issue_scoreboard
    import pipeline_pkg::*;
#(
    parameter  int unsigned NUM_REGS     = 32,
    parameter  int unsigned MAX_INFLIGHT = 4,
    parameter  int unsigned PERF_W       = 16,
    localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                stg_clk,
    input  logic                reset,
    issue_scoreboard_if.slave   sb,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [CNT_W-1:0]    inflight_count,
    output logic [PERF_W-1:0]   stall_cycles
);

    logic [NUM_REGS-1:0]  eff_busy;
    logic                 dst, raw, waw, full, wb_hit, do_issue;
    logic [CNT_W-1:0]     cnt_eff, inflight_q, inflight_d;
    logic [PERF_W-1:0]    stall_cycles_q;
    stall_cause_e         cause;
    sb_state_e            state_q;
    logic                 issue_valid_q, issue_save_q, issue_ldm_q;
    logic [31:0]          issue_pc_q;
    logic [REG_IDX_W-1:0] issue_rd_q;

    reg_busy_table #(
        .NUM_REGS (NUM_REGS)
    ) u_busy (
        .clk_i      (stg_clk),
        .rst_ni     (reset),
        .set_i      (do_issue & dst),
        .set_idx_i  (sb.in_rd),
        .clr_i      (sb.wb_valid),
        .clr_idx_i  (sb.wb_rd),
        .busy_o     (busy_mask),
        .eff_busy_o (eff_busy)
    );

    assign dst     = sb.in_save_to_reg & (sb.in_rd != '0);
    assign raw     = (sb.in_rs1_used & eff_busy[sb.in_rs1]) |
                     (sb.in_rs2_used & eff_busy[sb.in_rs2]);
    assign waw     = dst & eff_busy[sb.in_rd];
    // busy bit 0 is always clear, so writeback to x0 never counts as a hit
    assign wb_hit  = sb.wb_valid & busy_mask[sb.wb_rd];
    assign cnt_eff = inflight_q - CNT_W'(wb_hit);
    assign full    = dst & (cnt_eff == CNT_W'(MAX_INFLIGHT));

    always_comb begin
        cause = STALL_NONE;
        if (reset && sb.in_valid && !sb.flush) begin
            if (raw)       cause = STALL_RAW;
            else if (waw)  cause = STALL_WAW;
            else if (full) cause = STALL_FULL;
        end
    end

    assign sb.stall       = (cause != STALL_NONE);
    assign sb.stall_cause = cause;
    assign do_issue       = reset & sb.in_valid & ~sb.flush & ~sb.stall;
    assign inflight_d     = inflight_q + CNT_W'(do_issue & dst) - CNT_W'(wb_hit);

    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) begin
            state_q        <= SB_RUN;
            issue_valid_q  <= 1'b0;
            issue_pc_q     <= '0;
            issue_rd_q     <= '0;
            issue_save_q   <= 1'b0;
            issue_ldm_q    <= 1'b0;
            inflight_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            // flush already forces stall low, so it also forces RUN
            state_q       <= sb.stall ? SB_HOLD : SB_RUN;
            issue_valid_q <= do_issue;
            if (do_issue) begin
                issue_pc_q   <= sb.in_pc;
                issue_rd_q   <= sb.in_rd;
                issue_save_q <= sb.in_save_to_reg;
                issue_ldm_q  <= sb.in_rd_memory;
            end
            inflight_q <= inflight_d;
            if (sb.stall && (stall_cycles_q != '1))
                stall_cycles_q <= stall_cycles_q + 1'b1;
        end
    end

    a_hold_counted: assert property (@(posedge stg_clk) disable iff (!reset)
        (state_q == SB_HOLD) |-> (stall_cycles_q != '0));

    assign sb.issue_valid       = issue_valid_q;
    assign sb.issue_pc          = issue_pc_q;
    assign sb.issue_rd          = issue_rd_q;
    assign sb.issue_save_to_reg = issue_save_q;
    assign sb.issue_rd_memory   = issue_ldm_q;
    assign inflight_count       = inflight_q;
    assign stall_cycles         = stall_cycles_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed vector bench for issue_scoreboard: per-cycle table plus
// multi-cycle RAW hold and mid-operation reset sequences.
module tb_issue_scoreboard;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] busy_mask;
    logic [2:0]  inflight_count;
    logic [15:0] stall_cycles;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    issue_scoreboard_if sb ();

    issue_scoreboard #(
        .NUM_REGS     (32),
        .MAX_INFLIGHT (4),
        .PERF_W       (16)
    ) dut (
        .stg_clk        (clk),
        .reset          (rst_n),
        .sb             (sb),
        .busy_mask      (busy_mask),
        .inflight_count (inflight_count),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v, pc, rs1, rs2, rd, u1, u2, save, ld, fl, wbv, wbrd;
        int e_stall, e_cause, e_iv, e_pc, e_rd, e_busy, e_cnt, e_hold, e_ldm;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t x);
        sb.in_valid       = 1'(x.v);
        sb.in_pc          = 32'(x.pc);
        sb.in_rs1         = 5'(x.rs1);
        sb.in_rs2         = 5'(x.rs2);
        sb.in_rd          = 5'(x.rd);
        sb.in_rs1_used    = 1'(x.u1);
        sb.in_rs2_used    = 1'(x.u2);
        sb.in_save_to_reg = 1'(x.save);
        sb.in_rd_memory   = 1'(x.ld);
        sb.flush          = 1'(x.fl);
        sb.wb_valid       = 1'(x.wbv);
        sb.wb_rd          = 5'(x.wbrd);
    endtask

    task automatic idle();
        vec_t z;
        z = '{default: 0};
        drive(z);
    endtask

    task automatic instr(input int pc, input int rs1, input int u1, input int rd,
                         input int wbv, input int wbrd);
        vec_t z;
        z = '{default: 0};
        z.v = 1; z.pc = pc; z.rs1 = rs1; z.u1 = u1; z.rd = rd; z.save = 1;
        z.wbv = wbv; z.wbrd = wbrd;
        drive(z);
    endtask

    task automatic chk_regs(input string tag, input int iv, input int pc, input int rd,
                            input int busy, input int cnt);
        chk({tag, ".issue_valid"}, 32'(sb.issue_valid), iv);
        chk({tag, ".issue_pc"},    32'(sb.issue_pc), pc);
        chk({tag, ".issue_rd"},    32'(sb.issue_rd), rd);
        chk({tag, ".busy_mask"},   32'(busy_mask), busy);
        chk({tag, ".inflight"},    32'(inflight_count), cnt);
    endtask

    initial begin
        // v pc rs1 rs2 rd u1 u2 sv ld fl wbv wbrd | stall cause iv pc rd busy cnt hold ldm
        vecs[0]  = '{1,'h100,0,0,1, 1,0,1,0,0, 0,0, 0,0,1,'h100,1,'h002,1,0,0};
        vecs[1]  = '{1,'h104,0,0,2, 0,0,1,0,0, 0,0, 0,0,1,'h104,2,'h006,2,0,0};
        vecs[2]  = '{1,'h108,0,0,3, 0,0,1,0,0, 0,0, 0,0,1,'h108,3,'h00E,3,0,0};
        vecs[3]  = '{1,'h10C,0,0,5, 0,0,1,1,0, 0,0, 0,0,1,'h10C,5,'h02E,4,0,1};
        vecs[4]  = '{1,'h110,0,0,6, 0,0,1,0,0, 0,0, 1,3,0,'h10C,5,'h02E,4,1,1};
        vecs[5]  = '{1,'h114,0,0,6, 0,0,1,0,0, 1,1, 0,0,1,'h114,6,'h06C,4,0,0};
        vecs[6]  = '{1,'h118,5,0,8, 1,0,1,0,0, 0,0, 1,1,0,'h114,6,'h06C,4,1,0};
        vecs[7]  = '{1,'h11C,5,0,8, 1,0,1,0,0, 1,5, 0,0,1,'h11C,8,'h14C,4,0,0};
        vecs[8]  = '{1,'h120,0,0,3, 0,0,1,0,0, 1,2, 1,2,0,'h11C,8,'h148,3,1,0};
        vecs[9]  = '{1,'h124,0,0,0, 0,0,1,0,0, 1,0, 0,0,1,'h124,0,'h148,3,0,0};
        vecs[10] = '{1,'h128,3,0,9, 1,0,1,0,1, 0,0, 0,0,0,'h124,0,'h148,3,0,0};
        vecs[11] = '{0,'h12C,0,0,0, 0,0,0,0,0, 1,3, 0,0,0,'h124,0,'h140,2,0,0};
        vecs[12] = '{0,'h130,0,0,0, 0,0,0,0,0, 1,4, 0,0,0,'h124,0,'h140,2,0,0};
        vecs[13] = '{0,'h134,6,0,0, 1,0,0,0,0, 0,0, 0,0,0,'h124,0,'h140,2,0,0};

        idle();
        repeat (2) @(posedge clk);
        #1;
        chk_regs("reset", 0, 0, 0, 0, 0);
        chk("reset.stall_cycles", 32'(stall_cycles), 0);
        chk("reset.stall", 32'(sb.stall), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 14; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(vecs[i]);
            #1;
            chk({tag, ".stall"}, 32'(sb.stall), vecs[i].e_stall);
            chk({tag, ".cause"}, 32'(sb.stall_cause), vecs[i].e_cause);
            @(posedge clk);
            #1;
            chk_regs(tag, vecs[i].e_iv, vecs[i].e_pc, vecs[i].e_rd, vecs[i].e_busy, vecs[i].e_cnt);
            chk({tag, ".fsm_hold"}, 32'(dut.state_q), vecs[i].e_hold);
            chk({tag, ".rd_memory"}, 32'(sb.issue_rd_memory), vecs[i].e_ldm);
            @(negedge clk);
        end
        idle();
        chk("table.stall_cycles", 32'(stall_cycles), 3);

        // RAW on x8 held three cycles, released by same-cycle writeback
        instr('h300, 8, 1, 10, 0, 0);
        for (int unsigned k = 0; k < 3; k++) begin
            #1;
            chk("raw_hold.stall", 32'(sb.stall), 1);
            chk("raw_hold.cause", 32'(sb.stall_cause), 1);
            @(posedge clk);
            #1;
            chk("raw_hold.issue_valid", 32'(sb.issue_valid), 0);
            @(negedge clk);
        end
        sb.wb_valid = 1'b1;
        sb.wb_rd    = 5'd8;
        #1;
        chk("raw_rel.stall", 32'(sb.stall), 0);
        @(posedge clk);
        #1;
        chk_regs("raw_rel", 1, 'h300, 10, 'h440, 2);
        chk("raw_rel.stall_cycles", 32'(stall_cycles), 6);
        @(negedge clk);

        // Stall active on x6, then reset between edges
        instr('h400, 6, 1, 11, 0, 0);
        #1;
        chk("prerst.stall", 32'(sb.stall), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.stall", 32'(sb.stall), 0);
        chk_regs("midrst", 0, 0, 0, 0, 0);
        chk("midrst.stall_cycles", 32'(stall_cycles), 0);
        chk("midrst.fsm_hold", 32'(dut.state_q), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        instr('h200, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk_regs("postrst", 1, 'h200, 1, 'h002, 1);
        @(negedge clk);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
